// File: rtl/ahb_lite_master.sv
// AHB-Lite single-transfer bus master.
// Turns a valid/ready command stream into pipelined NONSEQ transfers and
// returns exactly one in-order response per accepted command.
//
// Handshake: a command transfers on a rising HCLK edge where
// cmd_valid && cmd_ready. rsp_valid is a one-cycle pulse with no
// backpressure; the requester must always take it.

`ifndef BUS_WIDTH
`define BUS_WIDTH 32
`endif
`ifndef IDLE
`define IDLE 2'b00
`endif
`ifndef NONSEQ
`define NONSEQ 2'b10
`endif
`ifndef OKAY
`define OKAY 1'b0
`endif
`ifndef ERROR
`define ERROR 1'b1
`endif

module ahb_lite_master (
    input  logic                  HCLK,
    input  logic                  HRESET,
    // command stream
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [`BUS_WIDTH-1:0] cmd_addr,
    input  logic [2:0]            cmd_size,
    input  logic [`BUS_WIDTH-1:0] cmd_wdata,
    // response stream
    output logic                  rsp_valid,
    output logic [`BUS_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_error,
    // AHB-Lite master side
    output logic [`BUS_WIDTH-1:0] HADDR,
    output logic                  HWRITE,
    output logic [2:0]            HSIZE,
    output logic [2:0]            HBURST,
    output logic [3:0]            HPROT,
    output logic [1:0]            HTRANS,
    output logic                  HMASTLOCK,
    output logic [`BUS_WIDTH-1:0] HWDATA,
    input  logic                  HREADY,
    input  logic                  HRESP,
    input  logic [`BUS_WIDTH-1:0] HRDATA
);

    // Non-cacheable, non-bufferable, privileged data access.
    localparam logic [3:0] HPROT_VALUE = 4'b0011;

    // A: address stage, D: data stage, R: replay slot for a command that
    // was in its address phase when the previous transfer took an ERROR.
    logic                  a_valid, a_write, a_err;
    logic [`BUS_WIDTH-1:0] a_addr, a_wdata;
    logic [2:0]            a_size;
    logic                  d_valid, d_write, d_err;
    logic [`BUS_WIDTH-1:0] d_addr, d_wdata;
    logic [2:0]            d_size;
    logic                  r_valid, r_write, r_err;
    logic [`BUS_WIDTH-1:0] r_addr, r_wdata;
    logic [2:0]            r_size;

    logic err1;
    logic accept;
    logic cmd_err;

    // Illegal sizes and unaligned addresses are flagged, never put on the bus.
    function automatic logic is_misaligned(input logic [2:0] size, input logic [1:0] lsb);
        return (size > 3'd2) ||
               ((size == 3'd1) && lsb[0]) ||
               ((size == 3'd2) && (lsb != 2'b00));
    endfunction

    // First cycle of the two-cycle ERROR response.
    assign err1    = d_valid && !HREADY && (HRESP == `ERROR);
    assign cmd_ready = !HRESET && HREADY && !r_valid && !err1;
    assign accept  = cmd_valid && cmd_ready;
    assign cmd_err = is_misaligned(cmd_size, cmd_addr[1:0]);

    // Bus address/control straight from the A stage; a flagged command is IDLE.
    assign HTRANS    = (a_valid && !a_err) ? `NONSEQ : `IDLE;
    assign HADDR     = a_addr;
    assign HWRITE    = a_write;
    assign HSIZE     = a_size;
    assign HBURST    = 3'b000;
    assign HPROT     = HPROT_VALUE;
    assign HMASTLOCK = 1'b0;
    assign HWDATA    = (d_valid && d_write) ? d_wdata : '0;

    // Pipeline advance, ERROR replay capture and response generation.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            a_valid   <= 1'b0; a_write <= 1'b0; a_err <= 1'b0;
            a_addr    <= '0;   a_wdata <= '0;   a_size <= 3'd0;
            d_valid   <= 1'b0; d_write <= 1'b0; d_err <= 1'b0;
            d_addr    <= '0;   d_wdata <= '0;   d_size <= 3'd0;
            r_valid   <= 1'b0; r_write <= 1'b0; r_err <= 1'b0;
            r_addr    <= '0;   r_wdata <= '0;   r_size <= 3'd0;
            rsp_valid <= 1'b0;
            rsp_error <= 1'b0;
            rsp_rdata <= '0;
        end else begin
            rsp_valid <= 1'b0;
            rsp_error <= 1'b0;
            rsp_rdata <= '0;
            if (HREADY) begin
                // Data phase (if any) completes; everything shifts forward.
                if (d_valid) begin
                    rsp_valid <= 1'b1;
                    rsp_error <= d_err || (HRESP == `ERROR);
                    rsp_rdata <= (!d_err && !d_write && (HRESP == `OKAY)) ? HRDATA : '0;
                end
                d_valid <= a_valid;
                d_write <= a_write;
                d_err   <= a_err;
                d_addr  <= a_addr;
                d_wdata <= a_wdata;
                d_size  <= a_size;
                if (r_valid) begin
                    a_valid <= 1'b1;
                    a_write <= r_write;
                    a_err   <= r_err;
                    a_addr  <= r_addr;
                    a_wdata <= r_wdata;
                    a_size  <= r_size;
                    r_valid <= 1'b0;
                end else if (accept) begin
                    a_valid <= 1'b1;
                    a_write <= cmd_write;
                    a_err   <= cmd_err;
                    a_addr  <= cmd_addr;
                    a_wdata <= cmd_wdata;
                    a_size  <= cmd_size;
                end else begin
                    a_valid <= 1'b0;
                end
            end else if (err1) begin
                // Pull the pending address phase back so e2 drives IDLE.
                if (a_valid) begin
                    r_valid <= 1'b1;
                    r_write <= a_write;
                    r_err   <= a_err;
                    r_addr  <= a_addr;
                    r_wdata <= a_wdata;
                    r_size  <= a_size;
                    a_valid <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_ahb_lite_master.sv
// Directed bench for ahb_lite_master: the bench plays the AHB-Lite slave by
// driving HREADY/HRESP/HRDATA cycle by cycle and checks hand-computed values.

`ifndef BUS_WIDTH
`define BUS_WIDTH 32
`endif

module tb_ahb_lite_master;

    logic                  HCLK = 1'b0;
    logic                  HRESET;
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic                  cmd_write;
    logic [`BUS_WIDTH-1:0] cmd_addr;
    logic [2:0]            cmd_size;
    logic [`BUS_WIDTH-1:0] cmd_wdata;
    logic                  rsp_valid;
    logic [`BUS_WIDTH-1:0] rsp_rdata;
    logic                  rsp_error;
    logic [`BUS_WIDTH-1:0] HADDR;
    logic                  HWRITE;
    logic [2:0]            HSIZE;
    logic [2:0]            HBURST;
    logic [3:0]            HPROT;
    logic [1:0]            HTRANS;
    logic                  HMASTLOCK;
    logic [`BUS_WIDTH-1:0] HWDATA;
    logic                  HREADY;
    logic                  HRESP;
    logic [`BUS_WIDTH-1:0] HRDATA;

    int n_vec = 0;
    int n_err = 0;

    ahb_lite_master dut (
        .HCLK      (HCLK),
        .HRESET    (HRESET),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_write (cmd_write),
        .cmd_addr  (cmd_addr),
        .cmd_size  (cmd_size),
        .cmd_wdata (cmd_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_error (rsp_error),
        .HADDR     (HADDR),
        .HWRITE    (HWRITE),
        .HSIZE     (HSIZE),
        .HBURST    (HBURST),
        .HPROT     (HPROT),
        .HTRANS    (HTRANS),
        .HMASTLOCK (HMASTLOCK),
        .HWDATA    (HWDATA),
        .HREADY    (HREADY),
        .HRESP     (HRESP),
        .HRDATA    (HRDATA)
    );

    // Clock: 10 time-unit period.
    always #5 HCLK = ~HCLK;

    // Watchdog so the run always ends.
    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    // Advance to 2 units after the next rising edge; inputs are driven here.
    task automatic cyc();
        @(posedge HCLK);
        #2;
    endtask

    task automatic set_cmd(input logic v, input logic w, input logic [31:0] a,
                           input logic [2:0] s, input logic [31:0] d);
        cmd_valid = v;
        cmd_write = w;
        cmd_addr  = a;
        cmd_size  = s;
        cmd_wdata = d;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        // ---------------- reset ----------------
        HRESET = 1'b1; HREADY = 1'b1; HRESP = 1'b0; HRDATA = '0;
        set_cmd(1'b1, 1'b1, 32'h100, 3'd2, 32'hFFFF_FFFF);
        cyc(); cyc(); #2;
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd0);
        chk("rst_htrans",    32'(HTRANS),    32'd0);
        chk("rst_haddr",     HADDR,          32'h0);
        chk("rst_hwrite",    32'(HWRITE),    32'd0);
        chk("rst_hsize",     32'(HSIZE),     32'd0);
        chk("rst_hburst",    32'(HBURST),    32'd0);
        chk("rst_hprot",     32'(HPROT),     32'd3);
        chk("rst_hmastlock", 32'(HMASTLOCK), 32'd0);
        chk("rst_hwdata",    HWDATA,         32'h0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_rdata", rsp_rdata,      32'h0);
        chk("rst_rsp_error", 32'(rsp_error), 32'd0);

        // ---------------- write, zero wait ----------------
        cyc(); HRESET = 1'b0;
        set_cmd(1'b1, 1'b1, 32'h10, 3'd2, 32'hDEAD_BEEF); #2;
        chk("wr_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("wr_c0_htrans", 32'(HTRANS),    32'd0);
        cyc(); cmd_valid = 1'b0; #2;
        chk("wr_c1_htrans", 32'(HTRANS), 32'd2);
        chk("wr_c1_haddr",  HADDR,       32'h10);
        chk("wr_c1_hwrite", 32'(HWRITE), 32'd1);
        chk("wr_c1_hsize",  32'(HSIZE),  32'd2);
        cyc(); #2;
        chk("wr_c2_hwdata",    HWDATA,         32'hDEAD_BEEF);
        chk("wr_c2_htrans",    32'(HTRANS),    32'd0);
        chk("wr_c2_rsp_valid", 32'(rsp_valid), 32'd0);
        cyc(); #2;
        chk("wr_c3_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("wr_c3_rsp_error", 32'(rsp_error), 32'd0);
        chk("wr_c3_rsp_rdata", rsp_rdata,      32'h0);
        chk("wr_c3_hwdata",    HWDATA,         32'h0);
        cyc(); #2;
        chk("wr_c4_rsp_valid", 32'(rsp_valid), 32'd0);

        // ---------------- pipelined reads ----------------
        cyc(); set_cmd(1'b1, 1'b0, 32'h0, 3'd2, 32'h0); #2;
        cyc(); set_cmd(1'b1, 1'b0, 32'h4, 3'd2, 32'h0); #2;
        chk("pr_c1_haddr",  HADDR,       32'h0);
        chk("pr_c1_htrans", 32'(HTRANS), 32'd2);
        chk("pr_c1_ready",  32'(cmd_ready), 32'd1);
        cyc(); cmd_valid = 1'b0; HRDATA = 32'h11; #2;
        chk("pr_c2_haddr",  HADDR,       32'h4);
        chk("pr_c2_htrans", 32'(HTRANS), 32'd2);
        chk("pr_c2_hwrite", 32'(HWRITE), 32'd0);
        cyc(); HRDATA = 32'h22; #2;
        chk("pr_c3_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("pr_c3_rsp_rdata", rsp_rdata,      32'h11);
        chk("pr_c3_htrans",    32'(HTRANS),    32'd0);
        cyc(); HRDATA = 32'h0; #2;
        chk("pr_c4_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("pr_c4_rsp_rdata", rsp_rdata,      32'h22);
        chk("pr_c4_rsp_error", 32'(rsp_error), 32'd0);
        cyc(); #2;
        chk("pr_c5_rsp_valid", 32'(rsp_valid), 32'd0);

        // ---------------- wait states ----------------
        cyc(); set_cmd(1'b1, 1'b0, 32'h20, 3'd2, 32'h0); #2;
        cyc(); set_cmd(1'b1, 1'b1, 32'h24, 3'd2, 32'hCAFE_F00D); #2;
        cyc(); set_cmd(1'b1, 1'b0, 32'h28, 3'd2, 32'h0); HREADY = 1'b0; #2;
        chk("ws_c2_ready",  32'(cmd_ready), 32'd0);
        chk("ws_c2_haddr",  HADDR,          32'h24);
        chk("ws_c2_htrans", 32'(HTRANS),    32'd2);
        chk("ws_c2_hwrite", 32'(HWRITE),    32'd1);
        cyc(); #2;
        chk("ws_c3_ready",     32'(cmd_ready), 32'd0);
        chk("ws_c3_haddr",     HADDR,          32'h24);
        chk("ws_c3_htrans",    32'(HTRANS),    32'd2);
        chk("ws_c3_rsp_valid", 32'(rsp_valid), 32'd0);
        cyc(); cmd_valid = 1'b0; HREADY = 1'b1; HRDATA = 32'h33; #2;
        chk("ws_c4_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("ws_c4_haddr",     HADDR,          32'h24);
        chk("ws_c4_htrans",    32'(HTRANS),    32'd2);
        cyc(); HRDATA = 32'h0; #2;
        chk("ws_c5_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("ws_c5_rsp_rdata", rsp_rdata,      32'h33);
        chk("ws_c5_hwdata",    HWDATA,         32'hCAFE_F00D);
        chk("ws_c5_htrans",    32'(HTRANS),    32'd0);
        cyc(); #2;
        chk("ws_c6_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("ws_c6_rsp_error", 32'(rsp_error), 32'd0);
        chk("ws_c6_rsp_rdata", rsp_rdata,      32'h0);
        cyc(); #2;
        chk("ws_c7_rsp_valid", 32'(rsp_valid), 32'd0);

        // ---------------- ERROR with pipelined successor ----------------
        cyc(); set_cmd(1'b1, 1'b1, 32'h400, 3'd2, 32'h55); #2;
        cyc(); set_cmd(1'b1, 1'b0, 32'h8, 3'd2, 32'h0); #2;
        chk("er_c1_haddr",  HADDR,       32'h400);
        chk("er_c1_htrans", 32'(HTRANS), 32'd2);
        cyc(); set_cmd(1'b1, 1'b0, 32'hC, 3'd2, 32'h0); HREADY = 1'b0; HRESP = 1'b1; #2;
        chk("er_e1_ready",  32'(cmd_ready), 32'd0);
        chk("er_e1_htrans", 32'(HTRANS),    32'd2);
        chk("er_e1_haddr",  HADDR,          32'h8);
        chk("er_e1_hwdata", HWDATA,         32'h55);
        cyc(); HREADY = 1'b1; #2;
        chk("er_e2_htrans",    32'(HTRANS),    32'd0);
        chk("er_e2_ready",     32'(cmd_ready), 32'd0);
        chk("er_e2_rsp_valid", 32'(rsp_valid), 32'd0);
        cyc(); HRESP = 1'b0; cmd_valid = 1'b0; #2;
        chk("er_r_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("er_r_rsp_error", 32'(rsp_error), 32'd1);
        chk("er_r_rsp_rdata", rsp_rdata,      32'h0);
        chk("er_r_htrans",    32'(HTRANS),    32'd2);
        chk("er_r_haddr",     HADDR,          32'h8);
        chk("er_r_hwrite",    32'(HWRITE),    32'd0);
        cyc(); HRDATA = 32'h44; #2;
        chk("er_d_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("er_d_htrans",    32'(HTRANS),    32'd0);
        cyc(); HRDATA = 32'h0; #2;
        chk("er_f_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("er_f_rsp_error", 32'(rsp_error), 32'd0);
        chk("er_f_rsp_rdata", rsp_rdata,      32'h44);

        // ---------------- misaligned word at 0x6 ----------------
        cyc(); set_cmd(1'b1, 1'b0, 32'h0, 3'd2, 32'h0); #2;
        cyc(); set_cmd(1'b1, 1'b0, 32'h6, 3'd2, 32'h0); #2;
        chk("ma_c1_haddr",  HADDR,       32'h0);
        chk("ma_c1_htrans", 32'(HTRANS), 32'd2);
        cyc(); cmd_valid = 1'b0; HRDATA = 32'h66; #2;
        chk("ma_c2_htrans", 32'(HTRANS), 32'd0);
        cyc(); HRDATA = 32'h77; #2;
        chk("ma_c3_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("ma_c3_rsp_rdata", rsp_rdata,      32'h66);
        chk("ma_c3_rsp_error", 32'(rsp_error), 32'd0);
        chk("ma_c3_htrans",    32'(HTRANS),    32'd0);
        cyc(); HRDATA = 32'h0; #2;
        chk("ma_c4_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("ma_c4_rsp_error", 32'(rsp_error), 32'd1);
        chk("ma_c4_rsp_rdata", rsp_rdata,      32'h0);
        cyc(); #2;
        chk("ma_c5_rsp_valid", 32'(rsp_valid), 32'd0);

        // ---------------- aligned halfword, then illegal size 3 ----------------
        cyc(); set_cmd(1'b1, 1'b0, 32'h2, 3'd1, 32'h0); #2;
        cyc(); set_cmd(1'b1, 1'b0, 32'h0, 3'd3, 32'h0); #2;
        chk("hs_c1_htrans", 32'(HTRANS), 32'd2);
        chk("hs_c1_haddr",  HADDR,       32'h2);
        chk("hs_c1_hsize",  32'(HSIZE),  32'd1);
        cyc(); cmd_valid = 1'b0; HRDATA = 32'h88; #2;
        chk("hs_c2_htrans", 32'(HTRANS), 32'd0);
        cyc(); HRDATA = 32'h0; #2;
        chk("hs_c3_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("hs_c3_rsp_error", 32'(rsp_error), 32'd0);
        chk("hs_c3_rsp_rdata", rsp_rdata,      32'h88);
        cyc(); #2;
        chk("hs_c4_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("hs_c4_rsp_error", 32'(rsp_error), 32'd1);
        chk("hs_c4_rsp_rdata", rsp_rdata,      32'h0);

        // ---------------- reset mid-transfer ----------------
        cyc(); set_cmd(1'b1, 1'b0, 32'h30, 3'd2, 32'h0); #2;
        cyc(); cmd_valid = 1'b0; #2;
        chk("rm_c1_htrans", 32'(HTRANS), 32'd2);
        cyc(); HREADY = 1'b0; HRESET = 1'b1; #2;
        chk("rm_c2_ready", 32'(cmd_ready), 32'd0);
        cyc(); HRESET = 1'b0; HREADY = 1'b1; HRDATA = 32'h99; #2;
        chk("rm_c3_htrans",    32'(HTRANS),    32'd0);
        chk("rm_c3_rsp_valid", 32'(rsp_valid), 32'd0);
        cyc(); HRDATA = 32'h0; set_cmd(1'b1, 1'b1, 32'h40, 3'd2, 32'h0000_1234); #2;
        chk("rm_c4_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rm_c4_ready",     32'(cmd_ready), 32'd1);
        cyc(); cmd_valid = 1'b0; #2;
        chk("rm_c5_htrans", 32'(HTRANS), 32'd2);
        chk("rm_c5_haddr",  HADDR,       32'h40);
        cyc(); #2;
        chk("rm_c6_hwdata", HWDATA, 32'h0000_1234);
        cyc(); #2;
        chk("rm_c7_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("rm_c7_rsp_error", 32'(rsp_error), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
